// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams 32-bit instruction words into byte-wide memory, little-endian, holding the core until done
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MEM_BYTES = 200,
    parameter int BASE_ADDR = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIM = MEM_BYTES[ADDR_W:0];
    localparam logic [ADDR_W:0] BASE    = BASE_ADDR[ADDR_W:0];

    state_t             state_q, state_d;
    // One extra address bit so the bound compare can never wrap.
    logic [ADDR_W:0]    addr_q, addr_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   num_words_q, num_words_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        word_q, word_d;
    logic               fits;

    assign fits = (addr_q + (ADDR_W+1)'(3)) < MEM_LIM;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= BASE;
            word_cnt_q  <= '0;
            num_words_q <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_cnt_q  <= word_cnt_d;
            num_words_q <= num_words_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_cnt_d  = word_cnt_q;
        num_words_d = num_words_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    num_words_d = num_words;
                    addr_d      = BASE;
                    word_cnt_d  = '0;
                    byte_idx_d  = '0;
                    state_d     = (num_words == '0) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (!fits) begin
                    state_d = ST_ERROR;
                end else if (s_valid) begin
                    word_d     = s_data;
                    byte_idx_d = '0;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    addr_d     = addr_q + (ADDR_W+1)'(4);
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    state_d    = (word_cnt_q + CNT_W'(1) == num_words_q) ? ST_DONE : ST_ACCEPT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory port is decoded from registered state only.
    always_comb begin
        s_ready   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_hold  = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state_q)
            ST_ACCEPT: s_ready = fits;
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, byte_idx_q};
                mem_wdata = word_q[8*byte_idx_q +: 8];
            end
            ST_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
            end
            ST_ERROR: load_err = 1'b1;
            default: ;
        endcase
    end

endmodule
